// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM wrapper and its access controller.
package sram_pkg;

  // Status codes reported by the SRAM wrapper on sram_state.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } sram_state_e;

  // Pattern the wrapper drives on read_data when no valid read is present.
  localparam logic [31:0] BAD_READ = 32'hBAD1BAD1;

  // Access controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/sram_access_ctrl.sv
// Initiator-side controller for the multi-cycle SRAM access protocol.
// Accepts one word request at a time, holds the SRAM bus stable until the
// wrapper reports ACCESS (or ERROR / timeout), then issues a one-cycle response.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] address,
  output logic              read_enable,
  output logic              write_enable,
  output logic [DATA_W-1:0] write_data,
  input  logic [1:0]        sram_state,
  input  logic [DATA_W-1:0] read_data
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  ctrl_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state and next-output decode for the access sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    re_d        = re_q;
    we_d        = we_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_write ? req_wdata : '0;
          we_d    = req_write;
          re_d    = ~req_write;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // ACCESS is checked first so it wins over a same-cycle timeout.
        if (sram_state == ACCESS) begin
          rsp_rdata_d = re_q ? read_data : '0;
          re_d        = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          state_d     = RELEASE;
        end else if ((sram_state == ERROR) || (cnt_q == CNT_MAX)) begin
          rsp_rdata_d = '0;
          re_d        = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        re_d        = 1'b0;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the SRAM enables immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      re_q        <= re_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign address      = addr_q;
  assign read_enable  = re_q;
  assign write_enable = we_q;
  assign write_data   = wdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl with a behavioural SRAM wrapper model.
module tb_sram_access_ctrl;
  import sram_pkg::*;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] address;
  logic              read_enable;
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic [1:0]        sram_state = FREE;
  logic [DATA_W-1:0] read_data = BAD_READ;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sram_access_ctrl #(
    .TIMEOUT(TIMEOUT),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .address     (address),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .write_data  (write_data),
    .sram_state  (sram_state),
    .read_data   (read_data)
  );

  // SRAM wrapper model. mode 0: normal (ACCESS visible 4 edges after the
  // enables appear), mode 1: ERROR on the first enabled edge, mode 2: BUSY forever.
  logic [DATA_W-1:0] mem [1024];
  int                mode = 0;
  int                mcnt = 0;

  initial foreach (mem[i]) mem[i] = '0;

  always @(posedge clk) begin
    if (!(read_enable || write_enable)) begin
      sram_state <= FREE;
      read_data  <= BAD_READ;
      mcnt       <= 0;
    end else if (mode == 1) begin
      sram_state <= ERROR;
    end else if (mode == 2) begin
      sram_state <= BUSY;
    end else if (mcnt < 3) begin
      mcnt       <= mcnt + 1;
      sram_state <= BUSY;
    end else begin
      sram_state <= ACCESS;
      if (write_enable) begin
        mem[address] <= write_data;
        read_data    <= write_data;
      end else begin
        read_data <= mem[address];
      end
    end
  end

  // Present a request and wait for acceptance; returns in the cycle after the accepting edge.
  task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output bit ok);
    logic [DATA_W-1:0] exp_wd;
    exp_wd = wr ? d : '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    ok = 1'b1;
    checks++;
    if ({read_enable, write_enable} !== {~wr, wr}) begin
      errors++;
      $display("FAIL enables_after_accept: re/we=%b%b required %b%b",
               read_enable, write_enable, ~wr, wr);
    end
    checks++;
    if (write_data !== exp_wd) begin
      errors++;
      $display("FAIL write_data: got %h required %h", write_data, exp_wd);
    end
  endtask

  // Watch WAIT for bus stability, then check the response against the scoreboard.
  task automatic wait_rsp(input logic wr, input logic [ADDR_W-1:0] a,
                          input int exp_lat, input bit pulse_during);
    int   k;
    exp_t e;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      checks++;
      if (address !== a || read_enable !== ~wr || write_enable !== wr) begin
        errors++;
        $display("FAIL hold k=%0d: addr=%h re=%b we=%b required addr=%h re=%b we=%b",
                 k, address, read_enable, write_enable, a, ~wr, wr);
      end
      if (pulse_during) begin
        req_valid = k[0];
        req_addr  = ~a;
        req_write = ~wr;
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 20 cycles", rsp_valid);
      return;
    end
    checks++;
    if (k != exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d required %0d", k, exp_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_rsp: got response, required none");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    checks++;
    if (rsp_error !== e.err) begin
      errors++;
      $display("FAIL rsp_error: got %b required %b", rsp_error, e.err);
    end
    checks++;
    if (rsp_rdata !== e.data) begin
      errors++;
      $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, e.data);
    end
    checks++;
    if (read_enable !== 1'b0 || write_enable !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL release: re=%b we=%b ready=%b required 0 0 0",
               read_enable, write_enable, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_rsp: valid=%b err=%b ready=%b required 0 0 1",
               rsp_valid, rsp_error, req_ready);
    end
    checks++;
    if (rsp_rdata !== e.data) begin
      errors++;
      $display("FAIL rdata_hold: got %h required %h", rsp_rdata, e.data);
    end
  endtask

  task automatic do_access(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic exp_err,
                           input logic [DATA_W-1:0] exp_data, input int exp_lat,
                           input bit pulse_during);
    bit ok;
    exp_q.push_back('{err: exp_err, data: exp_data});
    send_req(wr, a, d, ok);
    if (ok) wait_rsp(wr, a, exp_lat, pulse_during);
    else void'(exp_q.pop_back());
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b err=%b required 1 0 0",
               req_ready, rsp_valid, rsp_error);
    end
    checks++;
    if (address !== '0 || write_data !== '0 || rsp_rdata !== '0 ||
        read_enable !== 1'b0 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wd=%h rd=%h re=%b we=%b required all 0",
               address, write_data, rsp_rdata, read_enable, write_enable);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_write_read();
    do_access(1'b1, 10'h155, 32'hDEADBEEF, 1'b0, 32'h0, 5, 1'b0);
    do_access(1'b0, 10'h155, 32'h0, 1'b0, 32'hDEADBEEF, 5, 1'b0);
    do_access(1'b1, 10'h000, 32'h12345678, 1'b0, 32'h0, 5, 1'b0);
    do_access(1'b0, 10'h000, 32'h0, 1'b0, 32'h12345678, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 10'h3FF, 32'hA5A55A5A, 1'b0, 32'h0, 5, 1'b0);
    do_access(1'b0, 10'h3FF, 32'h0, 1'b0, 32'hA5A55A5A, 5, 1'b0);
    do_access(1'b0, 10'h3FF, 32'h0, 1'b0, 32'hA5A55A5A, 5, 1'b0);
  endtask

  task automatic test_sram_error();
    mode = 1;
    do_access(1'b0, 10'h155, 32'h0, 1'b1, 32'h0, 2, 1'b0);
    mode = 0;
    do_access(1'b0, 10'h155, 32'h0, 1'b0, 32'hDEADBEEF, 5, 1'b0);
  endtask

  task automatic test_timeout();
    mode = 2;
    do_access(1'b1, 10'h0AA, 32'h11111111, 1'b1, 32'h0, TIMEOUT, 1'b1);
    mode = 0;
    repeat (3) begin
      checks++;
      if (req_ready !== 1'b1 || read_enable !== 1'b0 || write_enable !== 1'b0) begin
        errors++;
        $display("FAIL stray_accept: ready=%b re=%b we=%b required 1 0 0",
                 req_ready, read_enable, write_enable);
      end
      @(negedge clk);
    end
    do_access(1'b0, 10'h0AA, 32'h0, 1'b0, 32'h0, 5, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    send_req(1'b0, 10'h155, 32'h0, ok);
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if (read_enable !== 1'b0 || write_enable !== 1'b0 || rsp_valid !== 1'b0 ||
        address !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: re=%b we=%b valid=%b addr=%h required 0 0 0 0",
               read_enable, write_enable, rsp_valid, address);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
      end
      @(negedge clk);
    end
    do_access(1'b0, 10'h155, 32'h0, 1'b0, 32'hDEADBEEF, 5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_sram_error();
    test_timeout();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
